// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART on the MEM-stage data bus: TXD/RXD/CON registers,
// independent TX and RX bit engines and a level interrupt.
module uart_periph #(
  parameter logic [15:0] BAUD_DIV  = 16'd5208,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        rx,
  output logic        tx,
  output logic        irq_uart
);

  localparam logic [29:0] TxdWord  = BASE_ADDR[31:2];
  localparam logic [29:0] RxdWord  = TxdWord + 30'd1;
  localparam logic [29:0] ConWord  = TxdWord + 30'd2;
  localparam logic [15:0] BaudLast = BAUD_DIV - 16'd1;
  localparam logic [15:0] HalfLast = (BAUD_DIV >> 1) - 16'd1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_byte_q, rx_shift_q, rx_shift_d, rx_data_q;
  logic [1:0]  irq_en_q, sync_q;
  logic        tx_done_q, rx_valid_q, tx_done_set, rx_byte_done;
  logic        hit_txd, hit_rxd, hit_con, txd_wr, con_wr, con_rd, rxd_rd, tx_busy, rx_s;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign hit_txd = (addr[31:2] == TxdWord);
  assign hit_rxd = (addr[31:2] == RxdWord);
  assign hit_con = (addr[31:2] == ConWord);
  assign hit     = hit_txd | hit_rxd | hit_con;

  assign tx_busy = (tx_state_q != StIdle);
  assign txd_wr  = mem_write & hit_txd & ~tx_busy;
  assign con_wr  = mem_write & hit_con;
  assign con_rd  = mem_read & hit_con;
  assign rxd_rd  = mem_read & hit_rxd;
  assign rx_s    = sync_q[1];

  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (hit_rxd) begin
        rdata = {24'b0, rx_data_q};
      end else if (hit_con) begin
        rdata = {27'b0, tx_busy, rx_valid_q, tx_done_q, irq_en_q};
      end
    end
  end

  // Combinational from state so an async reset forces the line idle at once.
  assign tx = (tx_state_q == StStart) ? 1'b0 :
              (tx_state_q == StData)  ? tx_byte_q[tx_bit_q] : 1'b1;

  assign irq_uart = (tx_done_q & irq_en_q[0]) | (rx_valid_q & irq_en_q[1]);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 16'd1;
    tx_bit_d    = tx_bit_q;
    tx_done_set = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (txd_wr) tx_state_d = StStart;
      end
      StStart: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end
      end
      StData: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = StStop;
        end
      end
      StStop: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d    = '0;
          tx_state_d  = StIdle;
          tx_done_set = 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 16'd1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_done = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (!rx_s) rx_state_d = StStart;
      end
      StStart: begin
        // Re-check the start bit at mid-bit; a short low pulse is dropped.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
        end
      end
      StStop: begin
        if (rx_cnt_q == BaudLast) begin
          rx_cnt_d     = '0;
          rx_state_d   = StIdle;
          rx_byte_done = rx_s;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_done_q  <= 1'b0;
      irq_en_q   <= '0;
      sync_q     <= 2'b11;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      if (txd_wr) tx_byte_q <= wdata[7:0];
      tx_done_q  <= tx_done_set | (tx_done_q & ~con_rd);
      if (con_wr) irq_en_q <= wdata[1:0];
      sync_q     <= {sync_q[0], rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      if (rx_byte_done) rx_data_q <= rx_shift_q;
      rx_valid_q <= rx_byte_done | (rx_valid_q & ~rxd_rd);
    end
  end

endmodule
